// File: rtl/sweep_peak_detector.sv
// sweep_peak_detector: per-sweep peak value, peak address and energy
// over a 0..LAST_ADDR address stream with RD_LAT cycles of sample latency.
module sweep_peak_detector #(
    parameter int              DW        = 12,
    parameter int              AW        = 10,
    parameter int              LAST_ADDR = 600,
    parameter int              RD_LAT    = 1,
    parameter logic [DW-1:0]   THRESH    = 12'd2048
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    address,
    input  logic [DW-1:0]    sample,
    output logic [DW-1:0]    peak_val,
    output logic [AW-1:0]    peak_addr,
    output logic [DW+9:0]    energy,
    output logic             result_valid,
    output logic             detect,
    output logic             sweep_err,
    output logic [7:0]       sweep_cnt
);
    localparam int EW = DW + 10;
    localparam logic [0:0] SYNC  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;
    localparam logic [AW-1:0] LAST = AW'(LAST_ADDR);

    logic [AW-1:0]     addr_pipe [RD_LAT];
    logic [RD_LAT-1:0] vld_pipe;
    logic [AW-1:0]     addr_d;
    logic              addr_vld;

    logic [0:0]        state;
    logic [AW-1:0]     prev_addr;
    logic [DW-1:0]     max_val;
    logic [AW-1:0]     max_addr;
    logic [EW-1:0]     sum;

    logic [AW:0]       prev_inc;
    logic              is_first;
    logic              is_next;
    logic              is_wrap;
    logic              is_last;
    logic              bigger;
    logic [DW-1:0]     nxt_max;
    logic [AW-1:0]     nxt_maddr;
    logic [EW-1:0]     nxt_sum;

    // Delay the address (and its validity) to line up with the returned sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) addr_pipe[i] <= '0;
            vld_pipe <= '0;
        end else begin
            addr_pipe[0] <= address;
            vld_pipe[0]  <= 1'b1;
            for (int i = 1; i < RD_LAT; i++) begin
                addr_pipe[i] <= addr_pipe[i-1];
                vld_pipe[i]  <= vld_pipe[i-1];
            end
        end
    end

    assign addr_d   = addr_pipe[RD_LAT-1];
    assign addr_vld = vld_pipe[RD_LAT-1];

    // Classify the aligned address and form the running max/sum update
    always_comb begin
        prev_inc  = {1'b0, prev_addr} + (AW+1)'(1);
        is_first  = addr_vld && (addr_d == '0);
        is_next   = (prev_addr != LAST) && ({1'b0, addr_d} == prev_inc);
        is_wrap   = (addr_d == '0) && (prev_addr == LAST);
        is_last   = (addr_d == LAST);
        bigger    = sample > max_val;
        nxt_max   = bigger ? sample : max_val;
        nxt_maddr = bigger ? addr_d : max_addr;
        nxt_sum   = sum + EW'(sample);
    end

    // Sweep FSM: sync on address 0, accumulate, report at the last address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SYNC;
            prev_addr    <= '0;
            max_val      <= '0;
            max_addr     <= '0;
            sum          <= '0;
            peak_val     <= '0;
            peak_addr    <= '0;
            energy       <= '0;
            detect       <= 1'b0;
            result_valid <= 1'b0;
            sweep_err    <= 1'b0;
            sweep_cnt    <= '0;
        end else begin
            result_valid <= 1'b0;
            prev_addr    <= addr_d;
            if (state == SYNC) begin
                if (is_first) begin
                    max_val  <= sample;
                    max_addr <= '0;
                    sum      <= EW'(sample);
                    state    <= ACCUM;
                end
            end else begin
                if (is_next) begin
                    max_val  <= nxt_max;
                    max_addr <= nxt_maddr;
                    sum      <= nxt_sum;
                    if (is_last) begin
                        peak_val     <= nxt_max;
                        peak_addr    <= nxt_maddr;
                        energy       <= nxt_sum;
                        detect       <= nxt_max >= THRESH;
                        result_valid <= 1'b1;
                        sweep_cnt    <= sweep_cnt + 8'd1;
                    end
                end else if (is_wrap) begin
                    max_val  <= sample;
                    max_addr <= '0;
                    sum      <= EW'(sample);
                end else begin
                    sweep_err <= 1'b1;
                    state     <= SYNC;
                end
            end
        end
    end
endmodule
